// File: rtl/arty_io_pkg.sv
// -----------------------------------------------------------------------------
// arty_io_pkg
//   Shared constants and types for the Arty board I/O conditioning blocks.
//
//   Channel map (default 8-channel build):
//     ch 3:0 : btn[3:0]   (BTN_CH_LO = 0, NUM_BTN = 4)
//     ch 7:4 : sw[3:0]    (SW_CH_LO  = 4, NUM_SW  = 4)
//
//   DEFAULT_STABLE_CYCLES is 10 ms at the 100 MHz system clock.
// -----------------------------------------------------------------------------
package arty_io_pkg;

    localparam int unsigned BTN_CH_LO             = 0;
    localparam int unsigned SW_CH_LO              = 4;
    localparam int unsigned NUM_BTN               = 4;
    localparam int unsigned NUM_SW                = 4;
    localparam int unsigned DEFAULT_STABLE_CYCLES = 1_000_000;

    // Debounced level of one channel.
    typedef enum logic {
        LVL_LOW  = 1'b0,
        LVL_HIGH = 1'b1
    } arty_lvl_e;

    // Width of the stability counter. It only has to hold 0..stable-1, so
    // $clog2(stable) bits suffice; a one-cycle filter still needs one bit.
    function automatic int unsigned cnt_width(input int unsigned stable);
        return (stable > 1) ? $clog2(stable) : 1;
    endfunction

endpackage

// File: rtl/arty_debounce_ch.sv
// -----------------------------------------------------------------------------
// arty_debounce_ch
//   Single-channel input conditioner: 2-FF synchronizer followed by a
//   counter-based debounce filter with registered rise/fall strobes.
//
//   Parameters:
//     STABLE_CYCLES  consecutive cycles the synchronized input must differ
//                    from the current level before the level flips (>= 1)
//
//   Ports:
//     clk      in   system clock
//     rst      in   synchronous, active-high reset
//     raw_i    in   asynchronous board input
//     level_o  out  debounced level (registered)
//     rise_o   out  one-cycle strobe on debounced 0->1 (registered)
//     fall_o   out  one-cycle strobe on debounced 1->0 (registered)
//
//   A raw step reaches level_o after STABLE_CYCLES+2 clock edges: two for the
//   synchronizer and STABLE_CYCLES for the filter.
// -----------------------------------------------------------------------------
module arty_debounce_ch
    import arty_io_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned     CntW   = cnt_width(STABLE_CYCLES);
    localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES - 1);

    if (STABLE_CYCLES < 1) begin : g_bad_param
        $error("arty_debounce_ch: STABLE_CYCLES must be >= 1");
    end

    // Synchronizer
    logic s1_q;
    logic s2_q;

    // Filter state
    logic [CntW-1:0] cnt_q, cnt_d;
    arty_lvl_e       level_q, level_d;
    logic            rise_q, rise_d;
    logic            fall_q, fall_d;
    logic            mismatch;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= raw_i;
            s2_q <= s1_q;
        end
    end

    always_comb begin
        mismatch = (s2_q != (level_q == LVL_HIGH));
        cnt_d    = '0;
        level_d  = level_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        if (mismatch) begin
            if (cnt_q == CntMax) begin
                // This is the STABLE_CYCLES-th consecutive mismatching cycle.
                level_d = s2_q ? LVL_HIGH : LVL_LOW;
                rise_d  = s2_q;
                fall_d  = ~s2_q;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
        // Any agreement with the level drops the count, so a short glitch
        // leaves no residue for the next mismatch.
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            level_q <= LVL_LOW;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o = (level_q == LVL_HIGH);
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/arty_input_debounce.sv
// -----------------------------------------------------------------------------
// arty_input_debounce
//   Conditions the Arty push-buttons and slide switches before they reach the
//   pulpino_arty GPIO/interrupt inputs. One arty_debounce_ch per channel;
//   channels are fully independent.
//
//   Parameters:
//     NUM_CH         number of channels (default btn[3:0] on 3:0, sw[3:0] on 7:4)
//     STABLE_CYCLES  debounce window in clk cycles (>= 1)
//
//   Ports:
//     clk        in   system clock, 100 MHz
//     rst        in   synchronous, active-high reset
//     evt_o      out  sticky rise flags       (ARTY_DEBOUNCE_EVT_LATCH_EN only)
//     evt_clr_i  in   per-bit clear of evt_o  (ARTY_DEBOUNCE_EVT_LATCH_EN only)
//     raw_i      in   asynchronous board inputs
//     level_o    out  debounced levels
//     rise_o     out  one-cycle strobes on debounced 0->1
//     fall_o     out  one-cycle strobes on debounced 1->0
//
//   Build option:
//     ARTY_DEBOUNCE_EVT_LATCH_EN  adds the sticky event-latch array. Without it
//                                 the evt ports and their logic do not exist.
//
//   All outputs are registered; there is no combinational path from raw_i.
// -----------------------------------------------------------------------------
module arty_input_debounce
    import arty_io_pkg::*;
#(
    parameter int unsigned NUM_CH        = NUM_BTN + NUM_SW,
    parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
`ifdef ARTY_DEBOUNCE_EVT_LATCH_EN
    output logic [NUM_CH-1:0] evt_o,
    input  logic [NUM_CH-1:0] evt_clr_i,
`endif
    input  logic [NUM_CH-1:0] raw_i,
    output logic [NUM_CH-1:0] level_o,
    output logic [NUM_CH-1:0] rise_o,
    output logic [NUM_CH-1:0] fall_o
);

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        arty_debounce_ch #(
            .STABLE_CYCLES (STABLE_CYCLES)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .raw_i   (raw_i[ch]),
            .level_o (level_o[ch]),
            .rise_o  (rise_o[ch]),
            .fall_o  (fall_o[ch])
        );
    end

`ifdef ARTY_DEBOUNCE_EVT_LATCH_EN
    logic [NUM_CH-1:0] evt_q, evt_d;

    // Set from the registered strobe, so evt_o follows rise_o by one cycle.
    // A clear presented while rise_o is high loses to the set.
    always_comb begin
        evt_d = (evt_q & ~evt_clr_i) | rise_o;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            evt_q <= '0;
        end else begin
            evt_q <= evt_d;
        end
    end

    assign evt_o = evt_q;
`endif

endmodule
